// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// codes, register-address width and the controller FSM encoding.
package hazard_ctrl_pkg;

    localparam int unsigned REG_AW = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MULTI = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding comparator: picks register file, EX result or WB
// data for one source operand of the instruction in ID.
module fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic              rs_used_i,
    input  logic [REG_AW-1:0] rd_addr_ex_i,
    input  logic              reg_we_ex_i,
    input  logic [REG_AW-1:0] rd_addr_wb_i,
    input  logic              reg_we_wb_i,
    output logic [1:0]        sel_o
);

    // x0 is hard-wired zero, so it is never forwarded; EX is the younger
    // producer and therefore wins over WB.
    always_comb begin
        sel_o = FWD_RF;
        if (rs_used_i && (rs_addr_i != '0)) begin
            if (reg_we_ex_i && (rd_addr_ex_i == rs_addr_i)) begin
                sel_o = FWD_EX;
            end else if (reg_we_wb_i && (rd_addr_wb_i == rs_addr_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: operand forwarding, load-use and
// multi-cycle EX stalls, wrong-path flush sequencing and perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_AW-1:0]    rs1_addr_id,
    input  logic [REG_AW-1:0]    rs2_addr_id,
    input  logic                 rs1_used_id,
    input  logic                 rs2_used_id,
    input  logic [REG_AW-1:0]    rd_addr_ex,
    input  logic                 reg_we_ex,
    input  logic                 mem_rd_ex,
    input  logic [REG_AW-1:0]    rd_addr_wb,
    input  logic                 reg_we_wb,
    input  logic                 br_taken_ex,
    input  logic                 ex_multi_start,
    input  logic                 ex_multi_done,
    input  logic                 dmem_stall,
    input  logic                 cnt_clr,
    output logic [1:0]           forward_a_sel,
    output logic [1:0]           forward_b_sel,
    output logic                 stall_pc,
    output logic                 stall_id,
    output logic                 stall_ex,
    output logic                 stall_wb,
    output logic                 bubble_ex,
    output logic                 bubble_wb,
    output logic                 flush_id,
    output logic                 redirect,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_cycles,
    output logic [1:0]           state_dbg_o,
    output logic [2:0]           fcnt_dbg_o
);

    localparam bit         HAS_FLUSH = (FLUSH_CYCLES != 0);
    localparam logic [2:0] FCNT_INIT = HAS_FLUSH ? 3'(FLUSH_CYCLES - 1) : 3'd0;

    hz_state_e            state_q, state_d;
    logic [2:0]           fcnt_q, fcnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]           fa_raw, fb_raw;
    logic                 load_use;

    fwd_sel u_fwd_a (
        .rs_addr_i    (rs1_addr_id),
        .rs_used_i    (rs1_used_id),
        .rd_addr_ex_i (rd_addr_ex),
        .reg_we_ex_i  (reg_we_ex),
        .rd_addr_wb_i (rd_addr_wb),
        .reg_we_wb_i  (reg_we_wb),
        .sel_o        (fa_raw)
    );

    fwd_sel u_fwd_b (
        .rs_addr_i    (rs2_addr_id),
        .rs_used_i    (rs2_used_id),
        .rd_addr_ex_i (rd_addr_ex),
        .reg_we_ex_i  (reg_we_ex),
        .rd_addr_wb_i (rd_addr_wb),
        .reg_we_wb_i  (reg_we_wb),
        .sel_o        (fb_raw)
    );

    assign load_use = mem_rd_ex && ((fa_raw == FWD_EX) || (fb_raw == FWD_EX));

    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        forward_a_sel = rst ? FWD_RF : fa_raw;
        forward_b_sel = rst ? FWD_RF : fb_raw;
        stall_pc      = 1'b0;
        stall_id      = 1'b0;
        stall_ex      = 1'b0;
        stall_wb      = 1'b0;
        bubble_ex     = 1'b0;
        bubble_wb     = 1'b0;
        flush_id      = 1'b0;
        redirect      = 1'b0;

        if (rst) begin
            // IF/ID content is meaningless until the first fetch after reset.
            flush_id = 1'b1;
            state_d  = ST_RUN;
            fcnt_d   = 3'd0;
        end else if (dmem_stall) begin
            stall_pc = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
            stall_wb = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (br_taken_ex) begin
                        redirect  = 1'b1;
                        flush_id  = 1'b1;
                        bubble_ex = 1'b1;
                        if (HAS_FLUSH) begin
                            state_d = ST_FLUSH;
                            fcnt_d  = FCNT_INIT;
                        end
                    end else if (ex_multi_start) begin
                        stall_pc  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        bubble_wb = 1'b1;
                        state_d   = ST_MULTI;
                    end else if (load_use) begin
                        // One bubble suffices: next cycle the load sits in WB.
                        stall_pc  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end
                end
                ST_MULTI: begin
                    if (ex_multi_done) begin
                        state_d = ST_RUN;
                    end else begin
                        stall_pc  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        bubble_wb = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (fcnt_q == 3'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    fcnt_d  = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_pc) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
            if (flush_id) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            fcnt_q      <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
    assign state_dbg_o  = state_q;
    assign fcnt_dbg_o   = fcnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the RV32I core. It sits beside the ID/EX/WB pipeline registers and decides every cycle whether each stage advances, holds, or takes a bubble. It produces the operand-forwarding selects, resolves load-use and multi-cycle EX hazards, and sequences the wrong-path flush after a taken branch or jump. It also counts stall and flush cycles for the CSR performance counters.

## Interface
- FLUSH_CYCLES, 1: extra cycles after a redirect during which the instruction arriving in ID is wrong-path (instruction-memory latency); legal range 0..7.
- CNT_WIDTH, 32: width of the performance counters.

- clk  in  1  core clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rs1_addr_id, rs2_addr_id  in  5  source registers of the instruction in ID.
- rs1_used_id, rs2_used_id  in  1  the instruction in ID actually reads rs1 / rs2.
- rd_addr_ex  in  5  destination of the instruction in EX.
- reg_we_ex  in  1  EX instruction writes the register file.
- mem_rd_ex  in  1  EX instruction is a load.
- rd_addr_wb  in  5  destination of the instruction in WB.
- reg_we_wb  in  1  WB instruction writes the register file.
- br_taken_ex  in  1  branch or jump in EX is taken.
- ex_multi_start  in  1  EX holds a multi-cycle op (iterative mul/div/CSR).
- ex_multi_done  in  1  the multi-cycle unit finishes this cycle.
- dmem_stall  in  1  data memory is not ready; freezes the whole pipeline.
- cnt_clr  in  1  clears both performance counters.
- forward_a_sel, forward_b_sel  out  2  operand source: 00 = register file, 01 = EX result, 10 = WB data.
- stall_pc, stall_id, stall_ex, stall_wb  out  1  hold the PC and the named pipeline register.
- bubble_ex, bubble_wb  out  1  load a NOP into ID/EX or EX/WB.
- flush_id  out  1  invalidate the IF/ID register.
- redirect  out  1  PC selects the branch target.
- stall_cycles, flush_cycles  out  CNT_WIDTH  performance counters.

## Operation
- FSM states: RUN, MULTI, FLUSH. A 3-bit down-counter `fcnt` is used in FLUSH.
- freeze = dmem_stall. Freeze overrides everything else:
  - all four stall outputs are 1;
  - bubble, flush and redirect outputs are 0;
  - the state and fcnt hold.
  - A pending redirect, flush or stall is applied on the first unfrozen cycle.
- Forwarding is combinational and evaluated in every state. For each source operand:
  - 00 if the operand is unused or its address is x0;
  - otherwise 01 if reg_we_ex and rd_addr_ex matches;
  - otherwise 10 if reg_we_wb and rd_addr_wb matches;
  - otherwise 00. EX has priority over WB.
- The following rules apply only when the pipeline is not frozen.
- RUN, in priority order:
  1. **br_taken_ex**: redirect=1, flush_id=1, bubble_ex=1. Go to FLUSH with fcnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>0; otherwise stay in RUN.
  2. **ex_multi_start**: stall_pc=stall_id=stall_ex=1 and bubble_wb=1. Go to MULTI. ex_multi_done is ignored while in RUN.
  3. **Load-use** (mem_rd_ex and a forwarding-EX match on either operand): stall_pc=stall_id=1 and bubble_ex=1 for one cycle. No state change is needed, because the load moves to WB and forwards 10 on the next cycle.
- MULTI:
  - Stall outputs are the same as in RUN rule 2 while ex_multi_done=0.
  - On the cycle ex_multi_done=1, all stalls are released and the state returns to RUN.
  - br_taken_ex is ignored in this state.
- FLUSH:
  - flush_id=1 and bubble_ex=1 every cycle; load-use is suppressed.
  - Leave to RUN when fcnt==0; otherwise decrement fcnt.
  - A new br_taken_ex here is ignored, because EX holds a bubble.
- Counters (wrap modulo 2^CNT_WIDTH):
  - stall_cycles increments on every cycle where stall_pc=1.
  - flush_cycles increments on every cycle where flush_id=1.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.

## Timing
- All control outputs are combinational from the state and the inputs; there is zero-cycle latency to the pipeline enables.
- A redirect asserts in the same cycle br_taken_ex is seen. flush_id stays high for 1+FLUSH_CYCLES consecutive unfrozen cycles.
- A load-use hazard costs exactly one bubble.
- A multi-cycle op with done k cycles after start stalls for k cycles.
- Reset:
  - While rst=1, outputs are: stall_* = 0, bubble_* = 0, redirect = 0, flush_id = 1, forward selects = 00.
  - On the edge, the state becomes RUN, fcnt becomes 0 and both counters become 0.
  - Reset mid-MULTI or mid-FLUSH abandons the operation.

## Structure
- Shared core package holds the forward-select constants (FWD_RF=2'b00, FWD_EX=2'b01, FWD_WB=2'b10) and the FSM state encoding.
- Sub-module fwd_sel: a combinational per-operand comparator, instantiated twice.
- The FSM, fcnt and the counters live in hazard_ctrl.

## Test plan
- **Forwarding priority:** rd_ex=5 with we=1, rd_wb=5 with we=1, rs1_id=5 used → forward_a_sel=01. Drop the EX write enable → 10. Set rs1_id=0 → 00.
- **Load-use:** load x6 in EX, rs2_id=6 used → stall_pc/stall_id/bubble_ex=1 for one cycle. Next cycle the load is in WB → forward_b_sel=10 and no stall. stall_cycles += 1.
- **Taken branch, FLUSH_CYCLES=2:** branch taken at cycle N → redirect at N only, flush_id at N..N+2, state RUN at N+3. flush_cycles += 3.
- **Multi-cycle op:** start at N, done at N+4 → stall_pc/stall_id/stall_ex and bubble_wb high for N..N+3, low at N+4. stall_cycles += 4.
- **Freeze during flush:** dmem_stall high for 3 cycles during FLUSH → all stalls=1 and flush_id=0 while frozen, fcnt holds. The remaining flush cycles complete afterward; stall_cycles += 3.
- **Reset and counter clear:** rst asserted during MULTI → RUN and counters=0 after the edge. cnt_clr together with an increment → counter reads 0.
